bip_sequencer: RTL and testbench
================================

// Module: bip_sequencer
// PURPOSE
//  Multi-cycle control unit for the BIP accumulator CPU. Owns the PC and the instruction register.
//  Sequences each instruction through FETCH/DECODE/EXEC.
//  Drives the datapath enables, program-memory address and data-memory strobes.
//  Stops on HLT and reports a cycle count for the debug/UART path.
// PARAMETERS
//  PC_W      11  program counter / program-memory address width
//  OPERAND_W 11  instruction operand field width (also data-memory address width)
//  DATA_W    16  datapath width; operand is sign-extended to this
//  CNT_W     32  cycle counter width
// PORTS
//  clk         in   1         system clock; all state on rising edge
//  reset       in   1         synchronous, active-high reset
//  start       in   1         1-cycle pulse: begin execution from PC=0 (honoured only in IDLE)
//  pm_addr     out  PC_W      program-memory address (= pc)
//  pm_data     in   16        instruction word, valid 1 cycle after pm_addr (sync ROM)
//  dm_addr     out  OPERAND_W data-memory address (= ir[10:0])
//  dm_wr_en    out  1         data-memory write strobe (STO)
//  dm_rd_en    out  1         data-memory read strobe (LD/ADD/SUB; DM read is combinational)
//  operand     out  DATA_W    sign-extended ir[10:0] for immediate path
//  sel_a       out  2         acc input mux: 0=ALU, 1=immediate, 2=DM data
//  sel_b       out  1         ALU B mux: 0=DM data, 1=immediate
//  alu_op      out  1         1=add, 0=subtract
//  acc_wr_en   out  1         accumulator load enable
//  busy        out  1         high in FETCH/DECODE/EXEC(/PAUSE)
//  halted      out  1         high in HALT
//  cycle_count out  CNT_W     executed-cycle counter
// BEHAVIOUR
//  - Instruction: opcode=ir[15:11], operand=ir[10:0].
//  - Opcodes: 0 HLT, 1 STO, 2 LD, 3 LDI, 4 ADD, 5 ADDI, 6 SUB, 7 SUBI; 8..31 = NOP.
//  - Reset: state=IDLE, pc=0, ir=0, cycle_count=0; every output low/zero; pm_addr=0.
//  - Reset mid-instruction aborts it; no DM write is issued on the reset cycle.
//  - FSM:
//    IDLE   -start-> FETCH (pc already 0).
//    FETCH  present pm_addr=pc; -> DECODE.
//    DECODE ir<=pm_data; -> EXEC.
//    EXEC   controls valid this cycle only.
//           opcode==HLT -> HALT, pc unchanged.
//           otherwise pc<=pc+1 (wraps 2^PC_W-1 -> 0); -> FETCH (or PAUSE, see CONFIGURATION).
//    HALT   absorbing; start ignored; only reset leaves.
//  - Throughput: 3 cycles per instruction; first EXEC is 3 cycles after start.
//  - Controls (combinational from state+ir); all 0 outside EXEC:
//    STO        dm_wr_en
//    LD         dm_rd_en, sel_a=2, acc_wr_en
//    LDI        sel_a=1, acc_wr_en
//    ADD/SUB    dm_rd_en, sel_a=0, sel_b=0, acc_wr_en, alu_op=1/0
//    ADDI/SUBI  sel_a=0, sel_b=1, acc_wr_en, alu_op=1/0
//    HLT, NOP   no enables
//  - cycle_count: +1 per cycle in FETCH/DECODE/EXEC, including the HLT EXEC cycle.
//    Saturates at all-ones. Frozen in IDLE/HALT/PAUSE.
//  - start outside IDLE is ignored; start coincident with reset is ignored.
// CONFIGURATION
//  BIP_SINGLE_STEP_EN defined:
//   - Adds inputs step_mode (level) and step (1-cycle pulse), plus state PAUSE.
//   - EXEC with step_mode=1 and non-HLT opcode -> PAUSE; PAUSE -step-> FETCH.
//   - step is ignored in other states.
//   - step_mode sampled only in EXEC; PAUSE holds pc (already incremented).
//  BIP_SINGLE_STEP_EN undefined:
//   - Ports and PAUSE state absent; EXEC -> FETCH directly.
// STRUCTURE
//  - Package bip_pkg: opcode localparams, FSM state encoding, ir field bounds, sel_a/sel_b codes.
//  - Sub-module bip_op_decode: pure combinational opcode -> {sel_a, sel_b, alu_op, acc_wr_en,
//    dm_wr_en, dm_rd_en, is_hlt}.
//  - Sequencer gates its enables with (state==EXEC).
// TESTING
//  1. Reset then start; ROM={LDI 5, ADDI 3, STO 7, HLT}: EXEC of STO shows dm_wr_en=1,
//     dm_addr=7. halted rises at cycle 12; cycle_count=12; pc=3.
//  2. ROM[0]=HLT: halted after 3 cycles; no enables ever high; later start pulse leaves state HALT.
//  3. ROM[0]=SUBI 0x7FF (-1): operand=16'hFFFF, sel_b=1, alu_op=0, acc_wr_en=1 for exactly one cycle.
//  4. Opcode 5'b11111: no enables; pc advances 0->1; next FETCH pm_addr=1.
//  5. PC_W=2, ROM all NOP: pm_addr sequence 0,1,2,3,0; reset asserted during EXEC of STO ->
//     dm_wr_en=0 that cycle; state IDLE; pc=0.
//  6. BIP_SINGLE_STEP_EN, step_mode=1: after each EXEC state PAUSE and cycle_count frozen;
//     one step pulse executes exactly one instruction.

Source files
------------

// File: rtl/bip_pkg.sv
// Shared definitions for the BIP accumulator CPU control path.
// Contents: instruction field bounds, opcode values, sequencer state encoding,
// accumulator/ALU mux select codes and the decoded control bundle.
// Optional feature macro: BIP_SINGLE_STEP_EN adds the StPause state.
package bip_pkg;

  // Instruction word layout: opcode in [15:11], operand in [10:0].
  localparam int unsigned InstrW     = 16;
  localparam int unsigned OpcodeMsb  = 15;
  localparam int unsigned OpcodeLsb  = 11;
  localparam int unsigned OpcodeW    = OpcodeMsb - OpcodeLsb + 1;
  localparam int unsigned OperandMsb = 10;

  localparam logic [OpcodeW-1:0] OpHlt  = 5'd0;
  localparam logic [OpcodeW-1:0] OpSto  = 5'd1;
  localparam logic [OpcodeW-1:0] OpLd   = 5'd2;
  localparam logic [OpcodeW-1:0] OpLdi  = 5'd3;
  localparam logic [OpcodeW-1:0] OpAdd  = 5'd4;
  localparam logic [OpcodeW-1:0] OpAddi = 5'd5;
  localparam logic [OpcodeW-1:0] OpSub  = 5'd6;
  localparam logic [OpcodeW-1:0] OpSubi = 5'd7;

  // Accumulator input mux and ALU B mux codes.
  localparam logic [1:0] SelAAlu = 2'd0;
  localparam logic [1:0] SelAImm = 2'd1;
  localparam logic [1:0] SelADm  = 2'd2;
  localparam logic       SelBDm  = 1'b0;
  localparam logic       SelBImm = 1'b1;

  typedef enum logic [2:0] {
    StIdle,
    StFetch,
    StDecode,
    StExec,
`ifdef BIP_SINGLE_STEP_EN
    StPause,
`endif
    StHalt
  } state_e;

  typedef struct packed {
    logic [1:0] sel_a;
    logic       sel_b;
    logic       alu_op;
    logic       acc_wr_en;
    logic       dm_wr_en;
    logic       dm_rd_en;
    logic       is_hlt;
  } ctrl_t;

endpackage

// File: rtl/bip_op_decode.sv
// Pure combinational opcode decoder for the BIP sequencer.
// Ports:
//   opcode_i  instruction opcode field (ir[15:11])
//   ctrl_o    raw control bundle; the sequencer qualifies it with the EXEC state
module bip_op_decode
  import bip_pkg::*;
(
  input  logic [OpcodeW-1:0] opcode_i,
  output ctrl_t              ctrl_o
);

  always_comb begin
    ctrl_o = '0;
    case (opcode_i)
      OpHlt: ctrl_o.is_hlt = 1'b1;
      OpSto: ctrl_o.dm_wr_en = 1'b1;
      OpLd: begin
        ctrl_o.dm_rd_en  = 1'b1;
        ctrl_o.sel_a     = SelADm;
        ctrl_o.acc_wr_en = 1'b1;
      end
      OpLdi: begin
        ctrl_o.sel_a     = SelAImm;
        ctrl_o.acc_wr_en = 1'b1;
      end
      OpAdd, OpSub: begin
        ctrl_o.dm_rd_en  = 1'b1;
        ctrl_o.sel_a     = SelAAlu;
        ctrl_o.sel_b     = SelBDm;
        ctrl_o.acc_wr_en = 1'b1;
        ctrl_o.alu_op    = (opcode_i == OpAdd);
      end
      OpAddi, OpSubi: begin
        ctrl_o.sel_a     = SelAAlu;
        ctrl_o.sel_b     = SelBImm;
        ctrl_o.acc_wr_en = 1'b1;
        ctrl_o.alu_op    = (opcode_i == OpAddi);
      end
      // Opcodes 8..31 are NOPs: no enables.
      default: ;
    endcase
  end

endmodule

// File: rtl/bip_sequencer.sv
// Multi-cycle control unit for the BIP accumulator CPU.
// Owns the PC and instruction register and walks each instruction through
// FETCH -> DECODE -> EXEC, stopping in HALT on the HLT opcode.
// Optional feature macro: BIP_SINGLE_STEP_EN adds step_mode/step inputs and a
// PAUSE state entered after each non-HLT EXEC while step_mode is high.
// Ports:
//   clk, reset        clock; synchronous active-high reset
//   start             begin execution from pc=0 (only honoured in IDLE)
//   step_mode, step   single-step controls (BIP_SINGLE_STEP_EN only)
//   pm_addr, pm_data  program-memory address (= pc) / instruction (sync ROM)
//   dm_addr, dm_wr_en, dm_rd_en  data-memory address (= operand) and strobes
//   operand           sign-extended operand for the immediate path
//   sel_a, sel_b, alu_op, acc_wr_en  datapath controls, live only in EXEC
//   busy, halted      run status
//   cycle_count       saturating count of FETCH/DECODE/EXEC cycles
module bip_sequencer
  import bip_pkg::*;
#(
  parameter int unsigned PC_W      = 11,
  parameter int unsigned OPERAND_W = 11,
  parameter int unsigned DATA_W    = 16,
  parameter int unsigned CNT_W     = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 start,
`ifdef BIP_SINGLE_STEP_EN
  input  logic                 step_mode,
  input  logic                 step,
`endif
  output logic [PC_W-1:0]      pm_addr,
  input  logic [InstrW-1:0]    pm_data,
  output logic [OPERAND_W-1:0] dm_addr,
  output logic                 dm_wr_en,
  output logic                 dm_rd_en,
  output logic [DATA_W-1:0]    operand,
  output logic [1:0]           sel_a,
  output logic                 sel_b,
  output logic                 alu_op,
  output logic                 acc_wr_en,
  output logic                 busy,
  output logic                 halted,
  output logic [CNT_W-1:0]     cycle_count
);

  state_e            state_q, state_d;
  logic [PC_W-1:0]   pc_q, pc_d;
  logic [InstrW-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  ctrl_t             dec;
  logic              exec_en;

  bip_op_decode u_op_decode (
    .opcode_i (ir_q[OpcodeMsb:OpcodeLsb]),
    .ctrl_o   (dec)
  );

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle:   if (start) state_d = StFetch;
      StFetch:  state_d = StDecode;
      StDecode: state_d = StExec;
      StExec: begin
        if (dec.is_hlt) begin
          state_d = StHalt;
`ifdef BIP_SINGLE_STEP_EN
        end else if (step_mode) begin
          state_d = StPause;
`endif
        end else begin
          state_d = StFetch;
        end
      end
`ifdef BIP_SINGLE_STEP_EN
      StPause:  if (step) state_d = StFetch;
`endif
      StHalt:   state_d = StHalt;
      default:  state_d = StIdle;
    endcase
  end

  // Datapath registers: pc, ir, cycle counter
  always_ff @(posedge clk) begin
    if (reset) begin
      pc_q  <= '0;
      ir_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ir_q  <= ir_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    pc_d  = pc_q;
    ir_d  = ir_q;
    cnt_d = cnt_q;
    // pc wraps naturally at 2^PC_W; HLT leaves it pointing at itself.
    if (state_q == StExec && !dec.is_hlt) begin
      pc_d = pc_q + PC_W'(1);
    end
    // Sync ROM: the word addressed in FETCH is on pm_data during DECODE.
    if (state_q == StDecode) begin
      ir_d = pm_data;
    end
    if ((state_q == StFetch || state_q == StDecode || state_q == StExec) && (cnt_q != '1)) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  // Outputs
  always_comb begin
    // Reset masks the strobes so an aborted EXEC never writes data memory.
    exec_en     = (state_q == StExec) && !reset;
    dm_wr_en    = exec_en && dec.dm_wr_en;
    dm_rd_en    = exec_en && dec.dm_rd_en;
    acc_wr_en   = exec_en && dec.acc_wr_en;
    alu_op      = exec_en && dec.alu_op;
    sel_b       = exec_en ? dec.sel_b : SelBDm;
    sel_a       = exec_en ? dec.sel_a : SelAAlu;
`ifdef BIP_SINGLE_STEP_EN
    busy        = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec) ||
                  (state_q == StPause);
`else
    busy        = (state_q == StFetch) || (state_q == StDecode) || (state_q == StExec);
`endif
    halted      = (state_q == StHalt);
    pm_addr     = pc_q;
    dm_addr     = ir_q[OPERAND_W-1:0];
    operand     = {{(DATA_W - OPERAND_W){ir_q[OPERAND_W-1]}}, ir_q[OPERAND_W-1:0]};
    cycle_count = cnt_q;
  end

endmodule

// File: tb/tb_bip_sequencer.sv
// Self-checking bench for bip_sequencer: directed and random programs checked
// cycle by cycle against an instruction-level timing model.
module tb_bip_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        step_mode;
  logic        step;

  logic [10:0] pm_addr;
  logic [15:0] pm_data;
  logic [10:0] dm_addr;
  logic        dm_wr_en, dm_rd_en;
  logic [15:0] operand;
  logic [1:0]  sel_a;
  logic        sel_b, alu_op, acc_wr_en, busy, halted;
  logic [31:0] cycle_count;

  // Second instance with a 2-bit pc fed a constant NOP stream.
  logic [1:0]  pm_addr2;
  logic [10:0] dm_addr2;
  logic        dm_wr_en2, dm_rd_en2;
  logic [15:0] operand2;
  logic [1:0]  sel_a2;
  logic        sel_b2, alu_op2, acc_wr_en2, busy2, halted2;
  logic [31:0] cycle_count2;

  logic [15:0] rom [0:2047];
  int          n_checks = 0;
  int          n_fail   = 0;

  always #5 clk = ~clk;
  always_ff @(posedge clk) pm_data <= rom[pm_addr];

  bip_sequencer dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef BIP_SINGLE_STEP_EN
    .step_mode   (step_mode),
    .step        (step),
`endif
    .pm_addr     (pm_addr),
    .pm_data     (pm_data),
    .dm_addr     (dm_addr),
    .dm_wr_en    (dm_wr_en),
    .dm_rd_en    (dm_rd_en),
    .operand     (operand),
    .sel_a       (sel_a),
    .sel_b       (sel_b),
    .alu_op      (alu_op),
    .acc_wr_en   (acc_wr_en),
    .busy        (busy),
    .halted      (halted),
    .cycle_count (cycle_count)
  );

  bip_sequencer #(.PC_W(2)) dut_small (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
`ifdef BIP_SINGLE_STEP_EN
    .step_mode   (1'b0),
    .step        (1'b0),
`endif
    .pm_addr     (pm_addr2),
    .pm_data     (16'h4000),
    .dm_addr     (dm_addr2),
    .dm_wr_en    (dm_wr_en2),
    .dm_rd_en    (dm_rd_en2),
    .operand     (operand2),
    .sel_a       (sel_a2),
    .sel_b       (sel_b2),
    .alu_op      (alu_op2),
    .acc_wr_en   (acc_wr_en2),
    .busy        (busy2),
    .halted      (halted2),
    .cycle_count (cycle_count2)
  );

  wire [6:0] ctrl  = {dm_wr_en, dm_rd_en, sel_a, sel_b, alu_op, acc_wr_en};
  wire [6:0] ctrl2 = {dm_wr_en2, dm_rd_en2, sel_a2, sel_b2, alu_op2, acc_wr_en2};

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Expected {dm_wr_en, dm_rd_en, sel_a, sel_b, alu_op, acc_wr_en} in EXEC.
  function automatic logic [6:0] model_ctrl(input logic [15:0] instr);
    logic [4:0] op;
    op = instr[15:11];
    case (op)
      5'd1:    return 7'b1_0_00_0_0_0;  // STO
      5'd2:    return 7'b0_1_10_0_0_1;  // LD
      5'd3:    return 7'b0_0_01_0_0_1;  // LDI
      5'd4:    return 7'b0_1_00_0_1_1;  // ADD
      5'd5:    return 7'b0_0_00_1_1_1;  // ADDI
      5'd6:    return 7'b0_1_00_0_0_1;  // SUB
      5'd7:    return 7'b0_0_00_1_0_1;  // SUBI
      default: return 7'b0;             // HLT, NOP
    endcase
  endfunction

  function automatic logic [15:0] model_operand(input logic [15:0] instr);
    int v;
    v = int'(instr[10:0]);
    if (v >= 1024) v = v - 2048;
    return 16'(v);
  endfunction

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start();
    @(posedge clk);
    #1 start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    next_cycle();
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_eq("rst_busy", busy, 0);
    check_eq("rst_halted", halted, 0);
    check_eq("rst_pm_addr", pm_addr, 0);
    check_eq("rst_count", cycle_count, 0);
    check_eq("rst_ctrl", ctrl, 0);
    check_eq("rst_operand", operand, 0);
    check_eq("rst_dm_addr", dm_addr, 0);
  endtask

  // rom[0..len-1] holds a program whose only HLT is its last word.
  task automatic run_prog(input string name, input int len);
    logic [15:0] instr;
    int          idx, ph;
    do_reset();
    pulse_start();
    for (int k = 1; k <= 3 * len; k++) begin
      if (k > 1) next_cycle();
      @(negedge clk);
      idx   = (k - 1) / 3;
      ph    = (k - 1) % 3;
      instr = rom[idx];
      check_eq({name, "_busy"}, busy, 1);
      check_eq({name, "_pm_addr"}, pm_addr, idx);
      check_eq({name, "_count"}, cycle_count, k - 1);
      check_eq({name, "_ctrl"}, ctrl, (ph == 2) ? model_ctrl(instr) : 7'b0);
      if (ph == 2) begin
        check_eq({name, "_dm_addr"}, dm_addr, instr[10:0]);
        check_eq({name, "_operand"}, operand, model_operand(instr));
      end
    end
    next_cycle();
    @(negedge clk);
    check_eq({name, "_halted"}, halted, 1);
    check_eq({name, "_halt_busy"}, busy, 0);
    check_eq({name, "_halt_count"}, cycle_count, 3 * len);
    check_eq({name, "_halt_pc"}, pm_addr, len - 1);
    pulse_start();
    next_cycle();
    @(negedge clk);
    check_eq({name, "_stay_halted"}, halted, 1);
    check_eq({name, "_stay_count"}, cycle_count, 3 * len);
    check_eq({name, "_stay_ctrl"}, ctrl, 0);
  endtask

  initial begin
    int len;
    reset     = 1'b1;
    start     = 1'b0;
    step_mode = 1'b0;
    step      = 1'b0;
    for (int i = 0; i < 2048; i++) rom[i] = 16'h4000;
    next_cycle();

    // start coincident with reset must be dropped
    reset = 1'b1;
    start = 1'b1;
    next_cycle();
    reset = 1'b0;
    start = 1'b0;
    @(negedge clk);
    check_eq("rst_start_busy", busy, 0);

    // LDI 5, ADDI 3, STO 7, HLT
    rom[0] = 16'h1805; rom[1] = 16'h2803; rom[2] = 16'h0807; rom[3] = 16'h0000;
    run_prog("basic", 4);

    rom[0] = 16'h0000;
    run_prog("hlt0", 1);

    rom[0] = 16'h3FFF; rom[1] = 16'h0000;  // SUBI -1
    run_prog("subi", 2);

    rom[0] = 16'hF923; rom[1] = 16'h0000;  // opcode 31 NOP
    run_prog("nop31", 2);

    for (int p = 0; p < 6; p++) begin
      len = int'($urandom_range(3, 12));
      for (int i = 0; i < len - 1; i++) begin
        rom[i] = {5'($urandom_range(1, 31)), 11'($urandom)};
      end
      rom[len - 1] = {5'd0, 11'($urandom)};
      run_prog("rand", len);
    end

    // Reset during EXEC of STO aborts it without a write strobe
    rom[0] = 16'h0807;
    do_reset();
    pulse_start();
    next_cycle();
    next_cycle();
    reset = 1'b1;
    @(negedge clk);
    check_eq("abort_wr_en", dm_wr_en, 0);
    next_cycle();
    reset = 1'b0;
    @(negedge clk);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_pc", pm_addr, 0);
    check_eq("abort_count", cycle_count, 0);

    // 2-bit pc wraps 3 -> 0 over a NOP stream
    do_reset();
    pulse_start();
    for (int k = 1; k <= 15; k++) begin
      if (k > 1) next_cycle();
      @(negedge clk);
      if ((k - 1) % 3 == 0) check_eq("wrap_pm_addr", pm_addr2, ((k - 1) / 3) % 4);
      check_eq("wrap_busy", busy2, 1);
      check_eq("wrap_halted", halted2, 0);
      check_eq("wrap_count", cycle_count2, k - 1);
      check_eq("wrap_ctrl", ctrl2, 0);
      if ((k - 1) % 3 == 2) begin
        check_eq("wrap_dm_addr", dm_addr2, 0);
        check_eq("wrap_operand", operand2, 0);
      end
    end

`ifdef BIP_SINGLE_STEP_EN
    // Single-step: LDI 5, ADDI 3, HLT
    rom[0] = 16'h1805; rom[1] = 16'h2803; rom[2] = 16'h0000;
    step_mode = 1'b1;
    do_reset();
    step = 1'b1;  // ignored in IDLE
    next_cycle();
    step = 1'b0;
    @(negedge clk);
    check_eq("step_idle_busy", busy, 0);
    pulse_start();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("step_exec0_ctrl", ctrl, model_ctrl(rom[0]));
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      @(negedge clk);
      check_eq("pause_busy", busy, 1);
      check_eq("pause_count", cycle_count, 3);
      check_eq("pause_pc", pm_addr, 1);
      check_eq("pause_ctrl", ctrl, 0);
    end
    step = 1'b1;
    next_cycle();
    step = 1'b0;
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("step_exec1_ctrl", ctrl, model_ctrl(rom[1]));
    check_eq("step_exec1_count", cycle_count, 5);
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("pause2_count", cycle_count, 6);
    check_eq("pause2_pc", pm_addr, 2);
    step_mode = 1'b0;
    step = 1'b1;
    next_cycle();
    step = 1'b0;
    next_cycle();
    next_cycle();
    next_cycle();
    @(negedge clk);
    check_eq("step_halted", halted, 1);
    check_eq("step_halt_count", cycle_count, 9);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
